// File: rtl/run_sequencer_if.sv
// Control/status bundle between the cpu run controller and whoever drives it.
// The master side issues start/step requests and forwards the cpu halt flag;
// the slave side (the sequencer) reports reset/enable and run status.
interface run_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             step_mode;
  logic             step;
  logic             halt;
  logic             cpu_reset;
  logic             cpu_en;
  logic [CNT_W-1:0] cycle_count;
  logic             busy;
  logic             done;
  logic             timeout;

  modport master (
    output start, step_mode, step, halt,
    input  cpu_reset, cpu_en, cycle_count, busy, done, timeout
  );

  modport slave (
    input  start, step_mode, step, halt,
    output cpu_reset, cpu_en, cycle_count, busy, done, timeout
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the cpu core: holds cpu reset for RESET_CYCLES after a
// start, then gates the cpu clock enable either free-running or one cycle per
// step pulse, stopping on halt or when MAX_CYCLES enabled cycles are used up.
module run_sequencer #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 100,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  run_sequencer_if.slave bus
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_PAUSE,
    S_STEP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             cpu_reset_q, cpu_en_q, busy_q;

  // Next-state and counter/flag update rules.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d       = state_q;
    hold_d        = hold_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d       = S_HOLD;
          hold_d        = HOLD_LOAD;
          cycle_count_d = '0;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = bus.step_mode ? S_PAUSE : S_RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      S_RUN, S_STEP: begin
        // The current enabled cycle always counts, whatever comes next.
        cycle_count_d = cycle_count_q + 1'b1;
        if (bus.halt) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (cycle_count_q == LAST_CNT) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (state_q == S_STEP || bus.step_mode) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.step)            state_d = S_STEP;
        else if (!bus.step_mode) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; outputs are decoded from the next state so they are
  // registered and carry no combinational path from the inputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cpu_reset_q   <= 1'b1;
      cpu_en_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cpu_reset_q   <= (state_d == S_IDLE) || (state_d == S_HOLD);
      cpu_en_q      <= (state_d == S_RUN)  || (state_d == S_STEP);
      busy_q        <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.cpu_en      = cpu_en_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;

endmodule
